// File: rtl/prog_mem_loader_if.sv
// Purpose: loader host-byte stream plus program-memory port A bundle.
// Latency: wiring only, no storage.
// Backpressure: rx_valid/rx_ready handshake; a byte moves when both are high.
// Ports: rx_data/rx_valid/rx_ready host link, cpu_addr fetch address in,
//        mem_addr/mem_wdata/mem_we to BRAM port A, cpu_rst/busy/load_done/load_err status.
// master = host/processor side, slave = loader.
interface prog_mem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [9:0]  cpu_addr;
    logic [9:0]  mem_addr;
    logic [17:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        cpu_rst;
    logic        busy;
    logic        load_done;
    logic        load_err;

    modport master (
        output rx_data, rx_valid, cpu_addr,
        input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_rst, busy, load_done, load_err
    );

    modport slave (
        input  rx_data, rx_valid, cpu_addr,
        output rx_ready, mem_addr, mem_wdata, mem_we, cpu_rst, busy, load_done, load_err
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Purpose: in-system loader and port-A arbiter for the 1K x 18 PicoBlaze program BRAM.
// Latency: one WRITE cycle per 3-byte word; cpu_addr -> mem_addr is combinational when idle.
// Backpressure: rx_ready low during WRITE, DONE and ERR; otherwise every byte is accepted.
// Ports: clk, rst_n (async active-low), bus (prog_mem_loader_if.slave).
// Frame: LOAD_CMD, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x {B2, B1, B0}.
// Optional: define LOADER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module prog_mem_loader #(
    parameter logic [7:0]  LOAD_CMD    = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter bit          BOOT_HOLD   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    prog_mem_loader_if.slave bus
);
    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_B2, S_B1, S_B0, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE, S_ERR
    } state_t;

    // State entered once the last word (or an empty frame) has been written.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = S_CHK;
`else
    localparam state_t FIN = S_DONE;
`endif

    state_t        state_q, state_d;
    logic          acc;
    logic          cmd_acc;
    logic [15:0]   cnt_full;
    logic [9:0]    ptr_q;
    logic [1:0]    addr_h_q;
    logic [7:0]    cnt_h_q;
    logic [10:0]   remain_q;
    logic [1:0]    b2_q;
    logic [7:0]    b1_q;
    logic [7:0]    b0_q;
    logic [TW-1:0] idle_q;
    logic          cnt_run;
    logic          byte_wait;
    logic          timed_out;
    logic          cpu_rst_q;
    logic          load_err_q;
    logic          rx_ready_w;
    logic [3:0]    we_w;
    logic          busy_w;
    logic          done_w;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    assign acc      = bus.rx_valid & rx_ready_w;
    assign cmd_acc  = (state_q == S_IDLE) && acc && (bus.rx_data == LOAD_CMD);
    // Count is only complete while the low byte is on the bus.
    assign cnt_full = {cnt_h_q, bus.rx_data};

    // Idle counter runs for the whole frame; only byte-waiting states can time out.
    assign cnt_run   = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign byte_wait = cnt_run && (state_q != S_WRITE);
    assign timed_out = byte_wait && !acc && (idle_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_acc) state_d = S_ADDR_H;
            S_ADDR_H: if (acc) state_d = S_ADDR_L;
            S_ADDR_L: if (acc) state_d = S_CNT_H;
            S_CNT_H:  if (acc) state_d = S_CNT_L;
            S_CNT_L: begin
                if (acc) begin
                    if (cnt_full > 16'd1024)    state_d = S_ERR;
                    else if (cnt_full == 16'd0) state_d = FIN;
                    else                        state_d = S_B2;
                end
            end
            S_B2:     if (acc) state_d = S_B1;
            S_B1:     if (acc) state_d = S_B0;
            S_B0:     if (acc) state_d = S_WRITE;
            S_WRITE:  state_d = (remain_q == 11'd1) ? FIN : S_B2;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:    if (acc) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
`endif
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (timed_out) state_d = S_ERR;
    end

    always_comb begin
        rx_ready_w = 1'b1;
        we_w       = 4'b0000;
        busy_w     = 1'b1;
        done_w     = 1'b0;
        case (state_q)
            S_IDLE:  busy_w = 1'b0;
            S_WRITE: begin
                rx_ready_w = 1'b0;
                we_w       = 4'b1111;
            end
            S_DONE: begin
                rx_ready_w = 1'b0;
                done_w     = 1'b1;
            end
            S_ERR: begin
                rx_ready_w = 1'b0;
                busy_w     = 1'b0;
            end
            default: ;
        endcase
    end

    // Frame datapath: header capture, word assembly, pointer/remaining bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            addr_h_q <= '0;
            cnt_h_q  <= '0;
            remain_q <= '0;
            b2_q     <= '0;
            b1_q     <= '0;
            b0_q     <= '0;
        end else begin
            if (acc) begin
                case (state_q)
                    S_ADDR_H: addr_h_q <= bus.rx_data[1:0];
                    S_ADDR_L: ptr_q    <= {addr_h_q, bus.rx_data};
                    S_CNT_H:  cnt_h_q  <= bus.rx_data;
                    S_CNT_L:  remain_q <= cnt_full[10:0];
                    S_B2:     b2_q     <= bus.rx_data[1:0];
                    S_B1:     b1_q     <= bus.rx_data;
                    S_B0:     b0_q     <= bus.rx_data;
                    default: ;
                endcase
            end
            if (state_q == S_WRITE) begin
                ptr_q    <= ptr_q + 10'd1;
                remain_q <= remain_q - 11'd1;
            end
        end
    end

    // Saturating idle counter; any accepted byte restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          idle_q <= '0;
        else if (acc || !cnt_run)            idle_q <= '0;
        else if (idle_q != TO_LAST)          idle_q <= idle_q + 1'b1;
    end

    // cpu_rst is held through ERR so a half-loaded image never runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst_q  <= BOOT_HOLD;
            load_err_q <= 1'b0;
        end else begin
            if (cmd_acc)                  cpu_rst_q <= 1'b1;
            else if (state_q == S_DONE)   cpu_rst_q <= 1'b0;

            if (cmd_acc)                  load_err_q <= 1'b0;
            else if (state_d == S_ERR)    load_err_q <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every byte after the command, checked in CHK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                     csum_q <= '0;
        else if (cmd_acc)                                               csum_q <= '0;
        else if (acc && (state_q inside {S_ADDR_H, S_ADDR_L, S_CNT_H,
                                         S_CNT_L, S_B2, S_B1, S_B0}))   csum_q <= csum_q ^ bus.rx_data;
    end
`endif

    assign bus.rx_ready  = rx_ready_w;
    assign bus.mem_we    = we_w;
    assign bus.mem_addr  = busy_w ? ptr_q : bus.cpu_addr;
    assign bus.mem_wdata = {b2_q, b1_q, b0_q};
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.busy      = busy_w;
    assign bus.load_done = done_w;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Purpose: randomized frame traffic against a queue-based write/outcome model of the loader.
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Backpressure: byte sender holds rx_valid until it sees rx_ready high before a rising edge.
module tb_prog_mem_loader;
    localparam int TO = 40;

    typedef struct packed {
        logic [9:0]  a;
        logic [17:0] d;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic clk;
    logic rst_n;
    prog_mem_loader_if bus();

    prog_mem_loader #(.LOAD_CMD(8'hA5), .TIMEOUT_CYC(TO), .BOOT_HOLD(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  n_vec = 0;
    int  n_bad = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    bit  prev_done = 0;
    bit  prev_err = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Random fetch address every cycle so passthrough is exercised continuously.
    initial begin
        bus.cpu_addr = '0;
        forever begin
            @(posedge clk);
            #1 bus.cpu_addr = 10'($urandom);
        end
    end

    // Compare process: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.busy) chk("passthru", 32'(bus.mem_addr), 32'(bus.cpu_addr));
            if (bus.mem_we != 4'h0) begin
                chk("we_all", 32'(bus.mem_we), 32'hF);
                chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.a));
                    chk("wr_data", 32'(bus.mem_wdata), 32'(mon_e.d));
                end
            end
            if (bus.load_done) begin
                done_cnt++;
                chk("done_cpu_rst", 32'(bus.cpu_rst), 32'd1);
            end
            if (prev_done) chk("rst_release", {30'd0, bus.cpu_rst, bus.busy}, 32'd0);
            if (bus.load_err && !prev_err) err_cnt++;
            prev_done = bus.load_done;
            prev_err  = bus.load_err;
        end else begin
            prev_done = 0;
            prev_err  = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("rx_accept", 32'(bus.rx_ready), 32'd1);
        bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] xor_tail(input bq_t f);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 1; i < f.size(); i++) cs ^= f[i];
        return cs;
    endfunction

    // Builds a frame; also queues the writes the model expects (writes land even on bad checksum).
    task automatic build_frame(input logic [9:0] st, input logic [15:0] cnt, input logic [17:0] w[$],
                               input bit corrupt, output bq_t f);
        logic [7:0] cs;
        f = {};
        f.push_back(8'hA5);
        f.push_back({6'($urandom), st[9:8]});
        f.push_back(st[7:0]);
        f.push_back(cnt[15:8]);
        f.push_back(cnt[7:0]);
        for (int i = 0; i < w.size(); i++) begin
            f.push_back({6'($urandom), w[i][17:16]});
            f.push_back(w[i][15:8]);
            f.push_back(w[i][7:0]);
            if (cnt <= 16'd1024) exp_q.push_back('{a: 10'((int'(st) + i) % 1024), d: w[i]});
        end
`ifdef LOADER_CHECKSUM_EN
        if (cnt <= 16'd1024) begin
            cs = xor_tail(f);
            f.push_back(corrupt ? ~cs : cs);
        end
`else
        cs = {7'd0, corrupt};
        if (cs[0]) f.push_back(8'h00);
`endif
    endtask

    // exp_err: 0 = frame completes, 1 = frame errors.
    task automatic run_frame(input bq_t f, input int exp_err);
        int d0, e0, n, got;
        d0 = done_cnt;
        e0 = err_cnt;
        foreach (f[i]) send_byte(f[i], $urandom_range(0, 2));
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < TO + 20) begin
            @(posedge clk);
            n++;
        end
        got = (err_cnt != e0) ? 1 : (done_cnt != d0) ? 0 : 2;
        chk("outcome", 32'(got), 32'(exp_err));
        @(negedge clk);
        chk("wr_left", 32'(exp_q.size()), 32'd0);
        chk("cpu_rst_after", 32'(bus.cpu_rst), 32'(exp_err));
        chk("err_after", 32'(bus.load_err), 32'(exp_err));
        chk("busy_after", 32'(bus.busy), 32'd0);
        exp_q = {};
        @(posedge clk);
        #1;
    endtask

    bq_t         f;
    logic [17:0] w[$];
    logic [9:0]  st;
    logic [7:0]  gb;
    int          c, d0, e0, n;
    bit          corrupt;

    initial begin
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_err", 32'(bus.load_err), 32'd0);
        @(posedge clk);
        #1;

        // Idle garbage byte is consumed without taking the port.
        d0 = done_cnt;
        send_byte(8'h3C, 1);
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        chk("idle_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk);
        #1;

        // Basic two-word load with literal expectations.
        f = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h02, 8'hAB, 8'hCD};
        exp_q.push_back('{a: 10'h010, d: 18'h00001});
        exp_q.push_back('{a: 10'h011, d: 18'h2ABCD});
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h77);
`endif
        run_frame(f, 0);

`ifdef LOADER_CHECKSUM_EN
        f = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h02, 8'hAB, 8'hCD, 8'h76};
        exp_q.push_back('{a: 10'h010, d: 18'h00001});
        exp_q.push_back('{a: 10'h011, d: 18'h2ABCD});
        run_frame(f, 1);
`endif

        // Pointer wraps from the top of memory.
        f = {8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'h67, 8'h89};
        exp_q.push_back('{a: 10'h3FF, d: 18'h12345});
        exp_q.push_back('{a: 10'h000, d: 18'h26789});
`ifdef LOADER_CHECKSUM_EN
        f.push_back(xor_tail(f));
`endif
        run_frame(f, 0);

        // Count one past the memory size is rejected right after CNT_L.
        f = {8'hA5, 8'h00, 8'h00, 8'h04, 8'h01};
        run_frame(f, 1);

        // Empty frame completes with no writes.
        f = {8'hA5, 8'h00, 8'h40, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h40);
`endif
        run_frame(f, 0);

        // Randomized frames, optional garbage between them.
        for (int k = 0; k < 12; k++) begin
            st = 10'($urandom);
            c  = $urandom_range(1, 6);
            w  = {};
            for (int i = 0; i < c; i++) w.push_back(18'($urandom));
`ifdef LOADER_CHECKSUM_EN
            corrupt = ($urandom_range(0, 3) == 0);
`else
            corrupt = 1'b0;
`endif
            if ($urandom_range(0, 1) == 1) begin
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h5A;
                send_byte(gb, 0);
            end
            build_frame(st, 16'(c), w, corrupt, f);
            run_frame(f, corrupt ? 1 : 0);
        end

        // Full-size frame: exactly 1024 words is legal and wraps back to the start.
        st = 10'($urandom);
        w  = {};
        for (int i = 0; i < 1024; i++) w.push_back(18'($urandom));
        build_frame(st, 16'd1024, w, 1'b0, f);
        run_frame(f, 0);

        // Timeout: stall after B1 of the first word.
        d0 = done_cnt;
        e0 = err_cnt;
        f = {8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h02, 8'hAB};
        foreach (f[i]) send_byte(f[i], 0);
        repeat (TO - 10) @(posedge clk);
        chk("no_early_timeout", 32'(err_cnt - e0), 32'd0);
        n = 0;
        while (err_cnt == e0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        chk("timeout_err", 32'(err_cnt - e0), 32'd1);
        @(negedge clk);
        chk("timeout_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("timeout_load_err", 32'(bus.load_err), 32'd1);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk);
        #1;

        // Reset asserted while the first word is being written.
        w = {18'h15555, 18'h2AAAA};
        build_frame(10'h100, 16'd2, w, 1'b0, f);
        exp_q = {};
        for (int i = 0; i < 8; i++) send_byte(f[i], (i == 7) ? 0 : $urandom_range(0, 2));
        chk("we_in_write", 32'(bus.mem_we), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        chk("rst_mid_rx_ready", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Loader recovers cleanly after the reset.
        w = {18'h3FFFF, 18'h00000, 18'h1F0F0};
        build_frame(10'h3FE, 16'd3, w, 1'b0, f);
        run_frame(f, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- In-system loader and port-A arbiter for the 1K x 18 PicoBlaze instruction block RAM.
- Receives a byte stream from the host link (e.g. a UART RX) and writes 18-bit instructions into program memory at a given start address.
- Holds the processor in reset while it owns the memory port; otherwise passes the processor's fetch address straight through.

Parameters:
- LOAD_CMD, 8'hA5, command byte that opens a load frame
- TIMEOUT_CYC, 1_000_000, max idle cycles between bytes inside a frame before abort
- BOOT_HOLD, 0, 1 = cpu_rst asserted from reset until first successful load; 0 = CPU runs from the INIT contents after reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid & rx_ready
- cpu_addr  in  10  processor instruction address
- mem_addr  out  10  address to program memory port A
- mem_wdata  out  18  write data to memory: {DIPA[1:0], DIA[15:0]}
- mem_we  out  4  port A byte write enables
- cpu_rst  out  1  processor reset, active high
- busy  out  1  loader owns memory port
- load_done  out  1  one-cycle pulse on successful frame completion
- load_err  out  1  sticky frame error

Behaviour:
- Reset values: state IDLE, rx_ready=1, mem_we=0, busy=0, load_done=0, load_err=0, cpu_rst=BOOT_HOLD. Async reset mid-frame aborts immediately; mem_we drops with reset; already-written words persist.
- Frame format: LOAD_CMD, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words of 3 bytes each, MSB first.
  - Start address = {ADDR_H[1:0], ADDR_L}; ADDR_H[7:2] ignored.
  - Word = {B2[1:0], B1, B0}; B2[7:2] ignored.
- States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, B2, B1, B0, WRITE, CHK (only with macro), DONE, ERR.
- IDLE: accepted byte == LOAD_CMD -> ADDR_H; cpu_rst=1, busy=1, load_err=0. Any other byte is consumed and ignored.
- Byte states advance one state per accepted byte.
- CNT_L -> exit decision:
  - CNT > 1024 -> ERR.
  - CNT == 0 -> DONE (or CHK with macro).
  - Otherwise -> B2.
- B0 accept -> WRITE.
- WRITE (exactly 1 cycle):
  - rx_ready=0, mem_we=4'b1111, mem_addr=load pointer, mem_wdata=assembled word.
  - Next cycle: pointer+1 (wraps 0x3FF -> 0x000), remaining-1.
  - remaining reaches 0 -> DONE (or CHK); else -> B2.
- DONE (1 cycle): load_done=1; cpu_rst=0 and busy=0 from the next cycle; -> IDLE.
- ERR (1 cycle): load_err=1 (sticky until next LOAD_CMD); cpu_rst stays 1; busy=0; -> IDLE.
- Timeout: in any state from ADDR_H to CHK, a counter reloads on each accepted byte. TIMEOUT_CYC cycles with no accepted byte -> ERR.
- Address mux: busy=1 -> mem_addr = loader pointer; busy=0 -> mem_addr = cpu_addr, combinational, zero latency. mem_we=0 whenever not in WRITE.
- rx_ready=1 in all states except WRITE, DONE and ERR.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every byte after LOAD_CMD (address, count, payload).
  - After the last word, state CHK accepts one checksum byte.
  - Match -> DONE; mismatch -> ERR, with cpu_rst left asserted. Memory is already written in either case.
- Undefined: no CHK state, no checksum byte; the last WRITE goes directly to DONE.

Test Plan:
- Basic load, macro off:
  - Stimulus: A5 00 10 00 02 00 00 01 02 AB CD.
  - Required: writes 0x00001 @0x010 and 0x2ABCD @0x011, each with mem_we=4'hF for one cycle; load_done pulses; cpu_rst falls on the cycle after load_done.
- Same frame plus checksum byte 77, macro on -> DONE. With checksum byte 76 -> load_err=1, cpu_rst stays 1, both writes still occurred.
- Wrap-around: A5 03 FF 00 02 plus two words -> writes land @0x3FF then @0x000.
- Error paths:
  - CNT=0x0401 -> ERR right after CNT_L, no writes.
  - CNT=0 -> load_done with no writes (macro off).
- Timeout: stop sending after B1 of word 1 for TIMEOUT_CYC cycles -> load_err=1, cpu_rst=1.
- Idle passthrough and mid-frame reset:
  - Byte 3C in IDLE is ignored; mem_addr tracks cpu_addr each cycle.
  - rst_n low during WRITE -> mem_we=0 immediately; state IDLE; cpu_rst=BOOT_HOLD.
